dbg_tap: RTL

// - Parametrised bit-serial debug tap controller. Next generation of the chipset

---
 rtl/dbg_pkg.sv | 20 ++
 rtl/dbg_tap_if.sv | 29 ++
 rtl/dbg_shreg.sv | 40 ++++
 rtl/dbg_tap.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug tap controller.
//   state_t      : controller state encoding
//   UTAP_*       : well-known tap domain numbers (0 is reserved for "idle")
//   ERR_WORD_DEF : default response word for timeouts and invalid domains
package dbg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_IN,
    REQ,
    SHIFT_OUT
  } state_t;

  localparam int UTAP_PC  = 1;
  localparam int UTAP_GPR = 2;
  localparam int UTAP_MEM = 3;

  localparam logic [15:0] ERR_WORD_DEF = 16'hDEAD;

endpackage

// File: rtl/dbg_tap_if.sv
// Core-side tap handshake bundle.
//   tap_req   : request, held until ack or timeout (controller -> core)
//   tap_dom   : latched domain, valid while tap_req   (controller -> core)
//   tap_arg   : shifted-in argument, valid while tap_req (controller -> core)
//   tap_ack   : completion strobe                    (core -> controller)
//   tap_rdata : response data, sampled with tap_ack  (core -> controller)
// Modports: master = controller side, slave = core side.
interface dbg_tap_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
) ();

  logic              tap_req;
  logic [SEL_W-1:0]  tap_dom;
  logic [DATA_W-1:0] tap_arg;
  logic              tap_ack;
  logic [DATA_W-1:0] tap_rdata;

  modport master (
    output tap_req, tap_dom, tap_arg,
    input  tap_ack, tap_rdata
  );

  modport slave (
    input  tap_req, tap_dom, tap_arg,
    output tap_ack, tap_rdata
  );

endinterface

// File: rtl/dbg_shreg.sv
// DATA_W-bit shift register for the debug tap.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (highest priority)
//   load       : parallel load of load_val
//   shift      : shift left by one, sin enters at bit 0
//   sin        : serial input
//   shifted    : value the register would take on a shift (used for capture)
//   msb        : current MSB, the serial output bit
module dbg_shreg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              shift,
  input  logic              sin,
  output logic [DATA_W-1:0] shifted,
  output logic              msb
);

  logic [DATA_W-1:0] q;

  assign shifted = {q[DATA_W-2:0], sin};
  assign msb     = q[DATA_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/dbg_tap.sv
// Bit-serial debug tap controller.
// A nonzero sel opens a frame: DATA_W argument bits are shifted in on dbg_rx
// (MSB first), one tap transaction runs on the tap interface, and a DATA_W
// response is shifted out on dbg_tx (MSB first).
//   clk, rst_n : clock, asynchronous active-low reset
//   sel        : domain select, nonzero opens a frame, zero aborts a frame
//   dbg_rx     : serial data in
//   dbg_tx     : serial data out
//   busy       : high in every state except IDLE
//   err        : sticky timeout / invalid-domain flag, cleared at frame start
//   tap        : tap handshake (master side)
module dbg_tap
  import dbg_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                SEL_W    = 3,
  parameter int                N_DOM    = 4,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_WORD_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic             dbg_rx,
  output logic             dbg_tx,
  output logic             busy,
  output logic             err,
  dbg_tap_if.master        tap
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [SEL_W-1:0]  dom_q;
  logic [CNT_W-1:0]  cnt;
  logic [TMR_W-1:0]  timer;
  logic              tx_en;

  logic              sh_clr;
  logic              sh_load;
  logic [DATA_W-1:0] sh_val;
  logic              sh_shift;
  logic              sh_in;
  logic [DATA_W-1:0] sh_shifted;
  logic              sh_msb;

  logic last_bit;
  logic dom_bad;
  logic timeout_hit;

  assign last_bit    = (cnt == CNT_W'(DATA_W - 1));
  assign dom_bad     = (int'(dom_q) >= N_DOM);
  assign timeout_hit = (timer == TMR_W'(TIMEOUT));

  // The shift register is cleared on abort and fully shifted out (zero fill)
  // at the end of a frame, so its MSB gated by tx_en is the serial output.
  assign dbg_tx = tx_en & sh_msb;

  always_comb begin
    sh_clr   = 1'b0;
    sh_load  = 1'b0;
    sh_val   = '0;
    sh_shift = 1'b0;
    sh_in    = 1'b0;
    case (state)
      SHIFT_IN: begin
        if (sel == '0) begin
          sh_clr = 1'b1;
        end else if (last_bit && dom_bad) begin
          sh_load = 1'b1;
          sh_val  = ERR_WORD;
        end else begin
          sh_shift = 1'b1;
          sh_in    = dbg_rx;
        end
      end
      REQ: begin
        // ack beats a simultaneous timeout
        if (tap.tap_ack) begin
          sh_load = 1'b1;
          sh_val  = tap.tap_rdata;
        end else if (timeout_hit) begin
          sh_load = 1'b1;
          sh_val  = ERR_WORD;
        end
      end
      SHIFT_OUT: begin
        if (sel == '0) sh_clr = 1'b1;
        else           sh_shift = 1'b1;
      end
      default: ;
    endcase
  end

  dbg_shreg #(.DATA_W(DATA_W)) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (sh_clr),
    .load     (sh_load),
    .load_val (sh_val),
    .shift    (sh_shift),
    .sin      (sh_in),
    .shifted  (sh_shifted),
    .msb      (sh_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dom_q       <= '0;
      cnt         <= '0;
      timer       <= '0;
      tx_en       <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      tap.tap_req <= 1'b0;
      tap.tap_dom <= '0;
      tap.tap_arg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel != '0) begin
            dom_q <= sel;
            err   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (sel == '0) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (last_bit) begin
            cnt <= '0;
            if (dom_bad) begin
              err   <= 1'b1;
              tx_en <= 1'b1;
              state <= SHIFT_OUT;
            end else begin
              // capture includes the bit arriving this cycle
              tap.tap_req <= 1'b1;
              tap.tap_arg <= sh_shifted;
              tap.tap_dom <= dom_q;
              timer       <= '0;
              state       <= REQ;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REQ: begin
          // sel is ignored here so a handshake is never torn
          if (tap.tap_ack) begin
            tap.tap_req <= 1'b0;
            tx_en       <= 1'b1;
            state       <= SHIFT_OUT;
          end else if (timeout_hit) begin
            tap.tap_req <= 1'b0;
            err         <= 1'b1;
            tx_en       <= 1'b1;
            state       <= SHIFT_OUT;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        SHIFT_OUT: begin
          if (sel == '0 || last_bit) begin
            cnt   <= '0;
            tx_en <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
